asteroids_stage_ctrl: RTL and testbench

ASTEROIDS_STAGE_CTRL -- requirements
Module: asteroids_stage_ctrl

---
 rtl/asteroids_stage_ctrl.sv | 172 +++++++++++++++++
 tb/tb_asteroids_stage_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroids_stage_ctrl.sv
// Stage sequencer for the asteroid field: IDLE -> ARM -> INTRO -> RUN -> DONE.
// Define ASTEROIDS_CTRL_PAUSE_EN to let the pause input freeze INTRO and RUN.
module asteroids_stage_ctrl #(
    parameter int INTRO_FRAMES     = 60,
    parameter int STAGE_FRAMES     = 1800,
    parameter int DONE_FRAMES      = 120,
    parameter int ASTEROIDS_AMOUNT = 20
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start_stage,
    input  logic        startOfFrame,
    input  logic        asteroid_exploded_pulse,
    input  logic        all_asteroids_destroied,
    input  logic        pause,
    output logic        asteroids_resetN,
    output logic        asteroids_enable,
    output logic        stage_active,
    output logic        stage_done_pulse,
    output logic        stage_won,
    output logic [4:0]  destroyed_count,
    output logic [10:0] frames_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_INTRO,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [10:0] STAGE_LOAD = 11'(STAGE_FRAMES);
    localparam logic [10:0] INTRO_LAST = 11'(INTRO_FRAMES - 1);
    localparam logic [10:0] DONE_LAST  = 11'(DONE_FRAMES - 1);
    localparam logic [4:0]  AMOUNT     = 5'(ASTEROIDS_AMOUNT);
    localparam bit          INTRO_SKIP = (INTRO_FRAMES == 0);
    localparam bit          DONE_SKIP  = (DONE_FRAMES == 0);

    state_t      r_state;
    logic        r_arm_last;
    logic [10:0] r_frame_cnt;
    logic        r_ast_rst_n;
    logic        r_enable;
    logic        r_active;
    logic        r_done_pulse;
    logic        r_won;
    logic [4:0]  r_count;
    logic [10:0] r_frames_left;

    logic        w_hold;
    logic        w_tick;
    logic        w_hit;
    logic [10:0] w_cnt_inc;

`ifdef ASTEROIDS_CTRL_PAUSE_EN
    assign w_hold = pause;
`else
    // Port kept for pin compatibility; folds to a constant 0.
    assign w_hold = pause & 1'b0;
`endif

    assign w_tick    = startOfFrame & ~w_hold;
    assign w_hit     = asteroid_exploded_pulse & ~w_hold;
    assign w_cnt_inc = (r_frame_cnt == 11'h7FF) ? r_frame_cnt
                                                : r_frame_cnt + 11'd1;

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state       <= S_IDLE;
            r_arm_last    <= 1'b0;
            r_frame_cnt   <= 11'd0;
            r_ast_rst_n   <= 1'b0;
            r_enable      <= 1'b0;
            r_active      <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_won         <= 1'b0;
            r_count       <= 5'd0;
            r_frames_left <= 11'd0;
        end else begin
            r_done_pulse <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_ast_rst_n <= 1'b1;
                    if (start_stage) begin
                        r_state       <= S_ARM;
                        r_ast_rst_n   <= 1'b0;
                        r_arm_last    <= 1'b0;
                        r_frame_cnt   <= 11'd0;
                        r_count       <= 5'd0;
                        r_frames_left <= STAGE_LOAD;
                        r_won         <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_arm_last <= 1'b1;
                    if (r_arm_last) begin
                        r_ast_rst_n <= 1'b1;
                        r_active    <= 1'b1;
                        if (INTRO_SKIP) begin
                            r_state  <= S_RUN;
                            r_enable <= 1'b1;
                        end else begin
                            r_state <= S_INTRO;
                        end
                    end
                end
                S_INTRO: begin
                    r_enable <= 1'b0;
                    if (w_tick) begin
                        if (r_frame_cnt == INTRO_LAST) begin
                            r_state     <= S_RUN;
                            r_enable    <= 1'b1;
                            r_frame_cnt <= 11'd0;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_RUN: begin
                    r_enable <= ~w_hold;
                    if (w_hit && (r_count < AMOUNT)) begin
                        r_count <= r_count + 5'd1;
                    end
                    // A clear outranks a coincident last tick.
                    if (all_asteroids_destroied && !w_hold) begin
                        r_state      <= S_DONE;
                        r_won        <= 1'b1;
                        r_done_pulse <= 1'b1;
                        r_enable     <= 1'b0;
                        r_active     <= 1'b0;
                        r_frame_cnt  <= 11'd0;
                    end else if (w_tick) begin
                        r_frames_left <= r_frames_left - 11'd1;
                        if (r_frames_left == 11'd1) begin
                            r_state      <= S_DONE;
                            r_won        <= 1'b0;
                            r_done_pulse <= 1'b1;
                            r_enable     <= 1'b0;
                            r_active     <= 1'b0;
                            r_frame_cnt  <= 11'd0;
                        end
                    end
                end
                S_DONE: begin
                    r_enable <= 1'b0;
                    if (DONE_SKIP) begin
                        r_state <= S_IDLE;
                    end else if (startOfFrame) begin
                        if (r_frame_cnt == DONE_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign asteroids_resetN = r_ast_rst_n;
    assign asteroids_enable = r_enable;
    assign stage_active     = r_active;
    assign stage_done_pulse = r_done_pulse;
    assign stage_won        = r_won;
    assign destroyed_count  = r_count;
    assign frames_left      = r_frames_left;

endmodule

// File: tb/tb_asteroids_stage_ctrl.sv
// Randomized stage scenarios; expected stage results are queued by the
// driver and popped by a monitor on every stage_done_pulse.
module tb_asteroids_stage_ctrl;

    localparam int INTRO = 60;
    localparam int STAGE = 1800;
    localparam int DONEF = 120;
    localparam int AMT   = 20;
`ifdef ASTEROIDS_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        start_stage = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        asteroid_exploded_pulse = 1'b0;
    logic        all_asteroids_destroied = 1'b0;
    logic        pause = 1'b0;
    logic        asteroids_resetN;
    logic        asteroids_enable;
    logic        stage_active;
    logic        stage_done_pulse;
    logic        stage_won;
    logic [4:0]  destroyed_count;
    logic [10:0] frames_left;

    asteroids_stage_ctrl #(
        .INTRO_FRAMES(INTRO),
        .STAGE_FRAMES(STAGE),
        .DONE_FRAMES(DONEF),
        .ASTEROIDS_AMOUNT(AMT)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .start_stage(start_stage),
        .startOfFrame(startOfFrame),
        .asteroid_exploded_pulse(asteroid_exploded_pulse),
        .all_asteroids_destroied(all_asteroids_destroied),
        .pause(pause),
        .asteroids_resetN(asteroids_resetN),
        .asteroids_enable(asteroids_enable),
        .stage_active(stage_active),
        .stage_done_pulse(stage_done_pulse),
        .stage_won(stage_won),
        .destroyed_count(destroyed_count),
        .frames_left(frames_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit won;
        int cnt;
        int fl;
    } res_t;

    res_t exp_q[$];
    res_t last;
    int   n_err = 0;
    int   n_chk = 0;
    int   arm_exp = 0;
    int   arm_seen = 0;

    function automatic void check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Monitor
    bit   rst_q = 1'b0;
    bit   rst_qq = 1'b0;
    bit   prev_done = 1'b0;
    bit   prev_en = 1'b0;
    bit   prev_arst = 1'b1;
    bit   rose = 1'b0;
    bit   low_rst = 1'b0;
    int   low_len = 0;
    int   intro_ticks = 0;
    res_t r;

    always @(posedge clk) begin
        rst_qq <= rst_q;
        rst_q  <= resetN;
    end

    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_ast_resetN", int'(asteroids_resetN), 0);
            check("rst_enable", int'(asteroids_enable), 0);
            check("rst_active", int'(stage_active), 0);
            check("rst_done", int'(stage_done_pulse), 0);
            check("rst_won", int'(stage_won), 0);
            check("rst_count", int'(destroyed_count), 0);
            check("rst_frames_left", int'(frames_left), 0);
        end else if (rst_qq) begin
            check("rst_release_ast_resetN", int'(asteroids_resetN), 1);
        end
        if (stage_done_pulse) begin
            check("done_width", int'(prev_done), 0);
            check("done_enable", int'(asteroids_enable), 0);
            check("done_active", int'(stage_active), 0);
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check("done_won", int'(stage_won), int'(r.won));
                check("done_count", int'(destroyed_count), r.cnt);
                check("done_frames_left", int'(frames_left), r.fl);
            end
        end
        if (asteroids_enable && !prev_en && !rose && stage_active) begin
            rose = 1'b1;
            check("intro_ticks", intro_ticks, INTRO);
        end
        if (!asteroids_resetN) begin
            low_len++;
            if (rst_q) low_rst = 1'b1;
            intro_ticks = 0;
            rose = 1'b0;
        end else if (!prev_arst) begin
            if (!low_rst) begin
                arm_seen++;
                check("arm_low_cycles", low_len, 2);
                check("arm_exit_active", int'(stage_active), 1);
            end
            low_len = 0;
            low_rst = 1'b0;
        end
        if (asteroids_resetN && stage_active && !asteroids_enable
            && !(PAUSE_EN && pause) && startOfFrame) begin
            intro_ticks++;
        end
        prev_done = stage_done_pulse;
        prev_en   = asteroids_enable;
        prev_arst = asteroids_resetN;
    end

    // Driver
    task automatic cyc(input bit t, input bit p, input bit c, input bit s);
        startOfFrame            = t;
        asteroid_exploded_pulse = p;
        all_asteroids_destroied = c;
        start_stage             = s;
        @(posedge clk);
        #1;
        startOfFrame            = 1'b0;
        asteroid_exploded_pulse = 1'b0;
        all_asteroids_destroied = 1'b0;
        start_stage             = 1'b0;
    endtask

    task automatic peek_run(input int elapsed, input string tag);
        @(negedge clk);
        check({tag, "_frames_left"}, int'(frames_left), STAGE - elapsed);
        check({tag, "_enable"}, int'(asteroids_enable),
              (PAUSE_EN && pause) ? 0 : 1);
        check({tag, "_active"}, int'(stage_active), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_stage(input int clear_at, input bit on_tick,
                             input int n_pulses, input int pause_from,
                             input int pause_len, input int rst_at);
        int   elapsed;
        int   pulses_in;
        int   issued;
        int   pticks;
        bit   done;
        bit   t;
        bit   p;
        bit   c;
        bit   s;
        bit   in_pause;
        bit   pk1;
        bit   pk2;
        res_t e;
        e.won = 1'b0;
        e.cnt = 0;
        e.fl  = 0;
        cyc(0, 0, 0, 1);
        arm_exp++;
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int f = 0; f < INTRO; f++) begin
            if ($urandom_range(0, 1) != 0) cyc(0, f == 5, 0, f == 30);
            cyc(1, 0, 0, 0);
        end
        elapsed   = 0;
        pulses_in = 0;
        issued    = 0;
        pticks    = 0;
        done      = 1'b0;
        pk1       = 1'b0;
        pk2       = 1'b0;
        while (!done) begin
            if (rst_at > 0 && elapsed == rst_at) begin
                resetN = 1'b1;
                cyc(0, 0, 0, 0);
                cyc(0, 0, 0, 0);
                resetN = 1'b0;
                repeat (3) cyc(0, 0, 0, 0);
                pause = 1'b0;
                return;
            end
            if (!pk1 && elapsed == 20) begin
                pk1 = 1'b1;
                peek_run(elapsed, "run");
            end
            if (!pk2 && pause && pticks == pause_len / 2) begin
                pk2 = 1'b1;
                peek_run(elapsed, "pause");
            end
            in_pause = (pause_len > 0) && (elapsed >= pause_from)
                       && (pticks < pause_len);
            pause = in_pause;
            t = ($urandom_range(0, 2) != 0);
            c = 1'b0;
            if (clear_at > 0 && !in_pause) begin
                if (!on_tick && elapsed == clear_at) begin
                    t = 1'b0;
                    c = 1'b1;
                end else if (on_tick && t && elapsed == clear_at - 1) begin
                    c = 1'b1;
                end
            end
            p = (issued < n_pulses) && ($urandom_range(0, 2) == 0);
            if (c && n_pulses > 0) p = 1'b1;
            s = (elapsed == 10) && !t;
            cyc(t, p, c, s);
            issued += int'(p);
            if (!(in_pause && PAUSE_EN)) begin
                if (p) pulses_in++;
                if (c) begin
                    done  = 1'b1;
                    e.won = 1'b1;
                    e.fl  = STAGE - elapsed;
                end else if (t) begin
                    elapsed++;
                    if (elapsed == STAGE) begin
                        done  = 1'b1;
                        e.won = 1'b0;
                        e.fl  = 0;
                    end
                end
            end
            if (in_pause && t) pticks++;
        end
        pause = 1'b0;
        e.cnt = (pulses_in > AMT) ? AMT : pulses_in;
        exp_q.push_back(e);
        last = e;
        for (int f = 0; f < DONEF - 1; f++) begin
            if ($urandom_range(0, 1) != 0) cyc(0, 1, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        @(negedge clk);
        check("idle_active", int'(stage_active), 0);
        check("idle_enable", int'(asteroids_enable), 0);
        check("idle_ast_resetN", int'(asteroids_resetN), 1);
        check("idle_won", int'(stage_won), int'(last.won));
        check("idle_count", int'(destroyed_count), last.cnt);
        check("idle_frames_left", int'(frames_left), last.fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) cyc(0, 0, 0, 0);
        resetN = 1'b0;
        repeat (2) cyc(0, 0, 0, 0);
        run_stage(500, 1'b0, 20, 0, 0, 0);
        run_stage(0, 1'b0, 5, 0, 0, 0);
        run_stage(STAGE, 1'b1, 25, 0, 0, 0);
        run_stage(0, 1'b0, 8, 0, 0, 100);
        run_stage(300, 1'b0, 10, 100, 50, 0);
        repeat (3) begin
            run_stage(int'($urandom_range(30, 400)),
                      $urandom_range(0, 1) != 0,
                      int'($urandom_range(0, 30)), 0, 0, 0);
        end
        repeat (5) cyc(0, 0, 0, 0);
        check("arm_count", arm_seen, arm_exp);
        check("results_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
